// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the round-robin mux arbiter: FSM state encodings and a sizing helper.
package mux_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  // Bits needed to count 0..max_hold inclusive (the hold counter saturates at max_hold).
  function automatic int hold_width(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from last+1, wrapping.
// Rotates req so last+1 lands at bit 0, priority-encodes, then un-rotates the index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int SEL_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  logic [NUM_REQ-1:0] rotated;
  int                 start_idx;
  int                 rot_idx;
  logic               found;

  always_comb begin
    start_idx = (int'(last) + 1) % NUM_REQ;
    rotated   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated[i] = req[(start_idx + i) % NUM_REQ];
    end

    found   = 1'b0;
    rot_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rotated[i] && !found) begin
        found   = 1'b1;
        rot_idx = i;
      end
    end

    any  = found;
    pick = SEL_W'((start_idx + rot_idx) % NUM_REQ);
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a shared NUM_REQ:1 data mux, with a hold limit and a
// one-cycle handover gap so sel never moves under a live transfer.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ARB_IDLE  | no owner; arbitrate among req from last+1, grant on next edge
// ARB_GRANT | owner active; capture its data each cycle, watch release/hold
// ARB_GAP   | single dead cycle after an owner leaves, grant forced to zero
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 8,
  localparam int SEL_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [SEL_W-1:0]              sel,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid
);

  localparam int HOLD_W = hold_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0]  LAST_RST  = SEL_W'(NUM_REQ - 1);

  arb_state_t              state, state_nxt;
  logic [NUM_REQ-1:0]      grant_nxt;
  logic [SEL_W-1:0]        sel_nxt;
  logic [SEL_W-1:0]        last, last_nxt;
  logic [HOLD_W-1:0]       hold, hold_nxt;
  logic [DATA_WIDTH-1:0]   out_data_nxt;
  logic                    out_valid_nxt;

  logic [SEL_W-1:0]        pick;
  logic                    pick_any;
  logic [DATA_WIDTH-1:0]   owner_data;
  logic                    owner_req;
  logic                    others_pending;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (pick_any)
  );

  // The shared mux: only ever addressed by the registered owner select.
  assign owner_data     = in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign owner_req      = req[sel];
  assign others_pending = |(req & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      sel       <= '0;
      last      <= LAST_RST;
      hold      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      sel       <= sel_nxt;
      last      <= last_nxt;
      hold      <= hold_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    sel_nxt       = sel;
    last_nxt      = last;
    hold_nxt      = hold;
    out_data_nxt  = out_data;
    out_valid_nxt = 1'b0;

    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          sel_nxt         = pick;
          last_nxt        = pick;
          hold_nxt        = '0;
          state_nxt       = ARB_GRANT;
        end
      end

      ARB_GRANT: begin
        out_data_nxt  = owner_data;
        out_valid_nxt = owner_req;
        if (hold != HOLD_SAT) begin
          hold_nxt = hold + HOLD_W'(1);
        end
        // Release takes precedence; a lone requester never hits forced rotation.
        if (!owner_req) begin
          grant_nxt = '0;
          state_nxt = ARB_GAP;
        end else if ((hold == HOLD_LAST) && others_pending) begin
          grant_nxt = '0;
          state_nxt = ARB_GAP;
        end
      end

      ARB_GAP: begin
        grant_nxt = '0;
        state_nxt = ARB_IDLE;
      end

      default: begin
        grant_nxt = '0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: a cycle table for arbitration/release/wrap plus
// hand sequences for async reset, full round robin, lone holder and release gap length.
module tb_mux_rr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int MAX_HOLD   = 8;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            grant;
  logic [1:0]                    sel;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .grant     (grant),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        ov;
    logic [31:0] od;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] word(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic ov, input logic [31:0] od);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_data"}, out_data, od);
  endtask

  initial begin
    int low;

    for (int i = 0; i < NUM_REQ; i++) in_data[i*DATA_WIDTH +: DATA_WIDTH] = word(i);

    // Each row: req applied, then one edge, then expected registered outputs.
    vecs[0]  = '{4'b1001, 4'b0001, 2'd0, 1'b0, 32'h0};
    vecs[1]  = '{4'b1001, 4'b0001, 2'd0, 1'b1, word(0)};
    vecs[2]  = '{4'b1000, 4'b0000, 2'd0, 1'b0, word(0)};
    vecs[3]  = '{4'b1000, 4'b0000, 2'd0, 1'b0, word(0)};
    vecs[4]  = '{4'b1000, 4'b1000, 2'd3, 1'b0, word(0)};
    vecs[5]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, word(3)};
    vecs[6]  = '{4'b0000, 4'b0000, 2'd3, 1'b0, word(3)};
    vecs[7]  = '{4'b0000, 4'b0000, 2'd3, 1'b0, word(3)};
    vecs[8]  = '{4'b0000, 4'b0000, 2'd3, 1'b0, word(3)};
    vecs[9]  = '{4'b0100, 4'b0100, 2'd2, 1'b0, word(3)};
    vecs[10] = '{4'b0110, 4'b0100, 2'd2, 1'b1, word(2)};
    vecs[11] = '{4'b0010, 4'b0000, 2'd2, 1'b0, word(2)};
    vecs[12] = '{4'b0010, 4'b0000, 2'd2, 1'b0, word(2)};
    vecs[13] = '{4'b0010, 4'b0010, 2'd1, 1'b0, word(2)};
    vecs[14] = '{4'b0010, 4'b0010, 2'd1, 1'b1, word(1)};

    // Reset values
    do_reset();
    check_outs("reset", 4'b0000, 2'd0, 1'b0, 32'h0);

    // Table: wrap from last=3, release, idle hold, pick after release
    for (int v = 0; v < 15; v++) begin
      req = vecs[v].req;
      step();
      check_outs($sformatf("vec%0d", v), vecs[v].grant, vecs[v].sel, vecs[v].ov, vecs[v].od);
    end

    // Single request latency
    do_reset();
    req = 4'b0100;
    check("single.pre_grant", 32'(grant), 32'h0);
    step();
    check_outs("single.e1", 4'b0100, 2'd2, 1'b0, 32'h0);
    step();
    check_outs("single.e2", 4'b0100, 2'd2, 1'b1, 32'hA5A5_0002);

    // Async reset mid-GRANT
    do_reset();
    req = 4'b0010;
    step();
    step();
    check_outs("pre_areset", 4'b0010, 2'd1, 1'b1, word(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("areset", 4'b0000, 2'd0, 1'b0, 32'h0);

    // Full round robin with all requesting, forced rotation at MAX_HOLD
    do_reset();
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        check($sformatf("rr.o%0d.c%0d.grant", o, c), 32'(grant), 32'(4'b0001 << (o % 4)));
        check($sformatf("rr.o%0d.c%0d.sel", o, c), 32'(sel), 32'(o % 4));
        check($sformatf("rr.o%0d.c%0d.ov", o, c), 32'(out_valid), (c == 0) ? 32'h0 : 32'h1);
        if (c != 0) check($sformatf("rr.o%0d.c%0d.od", o, c), out_data, word(o % 4));
      end
      if (o < 4) begin
        step();
        check($sformatf("rr.o%0d.gap", o), 32'(grant), 32'h0);
        step();
        check($sformatf("rr.o%0d.idle", o), 32'(grant), 32'h0);
      end
    end

    // Lone holder never rotates
    do_reset();
    req = 4'b0001;
    step();
    check("lone.first", 32'(grant), 32'h1);
    for (int c = 0; c < 40; c++) begin
      step();
      check($sformatf("lone.c%0d.grant", c), 32'(grant), 32'h1);
      check($sformatf("lone.c%0d.ov", c), 32'(out_valid), 32'h1);
    end

    // Owner 1 releases after 3 GRANT cycles while req[3] waits
    do_reset();
    req = 4'b1010;
    step();
    check("rel.grant1", 32'(grant), 32'h2);
    repeat (3) step();
    check("rel.ov_before", 32'(out_valid), 32'h1);
    req = 4'b1000;
    low = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid === 1'b0) low++;
      else break;
    end
    check("rel.ov_low_cycles", 32'(low), 32'd3);
    check("rel.grant3", 32'(grant), 32'h8);
    check("rel.od3", out_data, word(3));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
